iobuf_hdx_ctrl: RTL and testbench

- Core-side controller for a single bidirectional pad driven through an IOBUF-style tristate buffer.
- Drives the buffer's data (PAD_I) and tristate enable (PAD_T), and reads the buffer's input (PAD_O).
- Serialises one word per transaction, half-duplex, LSB first: either drives a word onto the line or releases the line and captures a word from it.
- Inserts a bus-release turnaround after every transmit. Sits between fabric logic and the pad buffer.

---
 rtl/iobuf_hdx_pkg.sv | 23 ++
 rtl/iobuf_hdx_bitclk.sv | 55 +++++
 rtl/iobuf_hdx_ctrl.sv | 135 +++++++++++++
 tb/tb_iobuf_hdx_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/iobuf_hdx_pkg.sv
// Shared types and helpers for the half-duplex single-pad IOBUF controller.
package iobuf_hdx_pkg;

    localparam int unsigned StateW = 2;

    localparam logic [StateW-1:0] EncIdle    = 2'd0;
    localparam logic [StateW-1:0] EncTxShift = 2'd1;
    localparam logic [StateW-1:0] EncTurn    = 2'd2;
    localparam logic [StateW-1:0] EncRxShift = 2'd3;

    typedef enum logic [StateW-1:0] {
        StIdle    = EncIdle,
        StTxShift = EncTxShift,
        StTurn    = EncTurn,
        StRxShift = EncRxShift
    } hdx_state_e;

    // Counter width for a counter running 0..n-1, never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iobuf_hdx_bitclk.sv
// Bit timing for iobuf_hdx_ctrl: per-bit divider and bit counter, both held at zero while idle.
module iobuf_hdx_bitclk
    import iobuf_hdx_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic bit_start_o,
    output logic sample_pt_o,
    output logic last_bit_o
);

    localparam int unsigned DivW = cnt_w(CLK_DIV);
    localparam int unsigned BitW = cnt_w(DATA_W);

    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivSample = DivW'(CLK_DIV / 2);
    localparam logic [BitW-1:0] BitLast   = BitW'(DATA_W - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [BitW-1:0] bit_q, bit_d;

    always_comb begin
        div_d = '0;
        bit_d = '0;
        if (run_i) begin
            if (div_q == DivLast) begin
                div_d = '0;
                bit_d = (bit_q == BitLast) ? '0 : bit_q + BitW'(1);
            end else begin
                div_d = div_q + DivW'(1);
                bit_d = bit_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
        end
    end

    // bit_start: the edge closing this cycle opens the next bit window.
    assign bit_start_o = run_i && (div_q == DivLast);
    assign sample_pt_o = run_i && (div_q == DivSample);
    assign last_bit_o  = (bit_q == BitLast);

endmodule

// File: rtl/iobuf_hdx_ctrl.sv
// Half-duplex serial controller for one IOBUF pad: LSB-first TX with turnaround, or RX capture.
// Define IOBUF_HDX_SYNC_EN to pass PAD_O through a 2-flop synchronizer (requires CLK_DIV >= 4).
module iobuf_hdx_ctrl
    import iobuf_hdx_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned TURN_CYC = 2
) (
    input  logic              C,
    input  logic              R,
    input  logic              TX_VALID,
    output logic              TX_READY,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              RX_REQ,
    output logic              RX_VALID,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              BUSY,
    output logic              PAD_I,
    output logic              PAD_T,
    input  logic              PAD_O
);

    localparam int unsigned TurnW = cnt_w(TURN_CYC);
    localparam logic [TurnW-1:0] TurnLast = TurnW'(TURN_CYC - 1);

    hdx_state_e        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [TurnW-1:0]  turn_q, turn_d;
    logic              pad_i_q, pad_i_d;
    logic              pad_t_q, busy_q, rx_valid_q, rx_valid_d;
    logic              bit_start, sample_pt, last_bit, line;

`ifdef IOBUF_HDX_SYNC_EN
    // Reset to the released-line level; sampling at the same divider count
    // therefore looks at the line two edges further back.
    logic [1:0] sync_q;
    always_ff @(posedge C) begin
        if (R) sync_q <= 2'b11;
        else   sync_q <= {sync_q[0], PAD_O};
    end
    assign line = sync_q[1];
`else
    assign line = PAD_O;
`endif

    iobuf_hdx_bitclk #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk_i       (C),
        .rst_i       (R),
        .run_i       ((state_q == StTxShift) || (state_q == StRxShift)),
        .bit_start_o (bit_start),
        .sample_pt_o (sample_pt),
        .last_bit_o  (last_bit)
    );

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        pad_i_d    = pad_i_q;
        turn_d     = turn_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        unique case (state_q)
            StIdle: begin
                if (TX_VALID) begin
                    state_d = StTxShift;
                    sh_d    = TX_DATA;
                    pad_i_d = TX_DATA[0];
                end else if (RX_REQ) begin
                    state_d = StRxShift;
                    sh_d    = '0;
                end
            end
            StTxShift: begin
                if (bit_start) begin
                    if (last_bit) begin
                        state_d = StTurn;
                        pad_i_d = 1'b0;
                        turn_d  = '0;
                    end else begin
                        sh_d    = sh_q >> 1;
                        pad_i_d = sh_d[0];
                    end
                end
            end
            StTurn: begin
                if (turn_q == TurnLast) state_d = StIdle;
                else                    turn_d  = turn_q + TurnW'(1);
            end
            StRxShift: begin
                if (sample_pt) sh_d = DATA_W'({line, sh_q} >> 1);
                if (bit_start && last_bit) begin
                    state_d    = StIdle;
                    rx_valid_d = 1'b1;
                    rx_data_d  = sh_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            turn_q     <= '0;
            pad_i_q    <= 1'b0;
            pad_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            turn_q     <= turn_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= (state_d != StTxShift);
            busy_q     <= (state_d != StIdle);
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign TX_READY = (state_q == StIdle) && !R;
    assign RX_VALID = rx_valid_q;
    assign RX_DATA  = rx_data_q;
    assign BUSY     = busy_q;
    assign PAD_I    = pad_i_q;
    assign PAD_T    = pad_t_q;

endmodule

// File: tb/tb_iobuf_hdx_ctrl.sv
// Self-checking bench for iobuf_hdx_ctrl: directed scenarios plus randomized TX/RX traffic.
module tb_iobuf_hdx_ctrl;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned TURN_CYC = 2;
    localparam int unsigned SER_LEN  = DATA_W * CLK_DIV;

    logic              C = 1'b0;
    logic              R;
    logic              TX_VALID;
    logic              TX_READY;
    logic [DATA_W-1:0] TX_DATA;
    logic              RX_REQ;
    logic              RX_VALID;
    logic [DATA_W-1:0] RX_DATA;
    logic              BUSY;
    logic              PAD_I;
    logic              PAD_T;
    logic              PAD_O;

    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;
    logic [DATA_W-1:0] model_rx = '0;

    always #5 C = ~C;

    iobuf_hdx_ctrl #(
        .DATA_W   (DATA_W),
        .CLK_DIV  (CLK_DIV),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .C        (C),
        .R        (R),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .TX_DATA  (TX_DATA),
        .RX_REQ   (RX_REQ),
        .RX_VALID (RX_VALID),
        .RX_DATA  (RX_DATA),
        .BUSY     (BUSY),
        .PAD_I    (PAD_I),
        .PAD_T    (PAD_T),
        .PAD_O    (PAD_O)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("idle_rx_valid", RX_VALID, 0);
            check_eq("idle_busy", BUSY, 0);
            check_eq("idle_pad_t", PAD_T, 1);
            check_eq("idle_rx_data", RX_DATA, model_rx);
        end
    endtask

    // Starts in an idle cycle, ends in the first idle cycle after the transaction.
    task automatic do_tx(input logic [DATA_W-1:0] d, input bit also_rx, input bit noise);
        check_eq("tx_ready_pre", TX_READY, 1);
        TX_VALID = 1'b1;
        TX_DATA  = d;
        RX_REQ   = also_rx;
        tick();
        TX_VALID = 1'b0;
        RX_REQ   = 1'b0;
        TX_DATA  = DATA_W'($urandom);
        for (int j = 0; j < int'(SER_LEN + TURN_CYC); j++) begin
            if (noise) begin
                RX_REQ   = 1'($urandom_range(0, 1));
                TX_VALID = 1'($urandom_range(0, 1));
            end
            PAD_O = 1'($urandom_range(0, 1));
            if (j < int'(SER_LEN)) begin
                check_eq("tx_pad_t", PAD_T, 0);
                check_eq("tx_pad_i", PAD_I, d[j / CLK_DIV]);
            end else begin
                check_eq("turn_pad_t", PAD_T, 1);
                check_eq("turn_pad_i", PAD_I, 0);
            end
            check_eq("tx_busy", BUSY, 1);
            check_eq("tx_ready_busy", TX_READY, 0);
            check_eq("tx_no_rx_valid", RX_VALID, 0);
            tick();
        end
        RX_REQ   = 1'b0;
        TX_VALID = 1'b0;
        check_eq("tx_done_ready", TX_READY, 1);
        check_eq("tx_done_busy", BUSY, 0);
        check_eq("tx_done_pad_t", PAD_T, 1);
        check_eq("tx_done_rx_valid", RX_VALID, 0);
        check_eq("tx_done_rx_data", RX_DATA, model_rx);
    endtask

    // Line model drives bit n for the whole n-th window; ends in the RX_VALID cycle.
    task automatic do_rx(input logic [DATA_W-1:0] d, input bit noise);
        check_eq("rx_ready_pre", TX_READY, 1);
        RX_REQ   = 1'b1;
        TX_VALID = 1'b0;
        tick();
        RX_REQ = 1'b0;
        for (int j = 0; j < int'(SER_LEN); j++) begin
            PAD_O = d[j / CLK_DIV];
            if (noise) begin
                RX_REQ   = 1'($urandom_range(0, 1));
                TX_VALID = 1'($urandom_range(0, 1));
                TX_DATA  = DATA_W'($urandom);
            end
            check_eq("rx_pad_t", PAD_T, 1);
            check_eq("rx_busy", BUSY, 1);
            check_eq("rx_ready_busy", TX_READY, 0);
            check_eq("rx_valid_early", RX_VALID, 0);
            tick();
        end
        RX_REQ   = 1'b0;
        TX_VALID = 1'b0;
        PAD_O    = 1'($urandom_range(0, 1));
        model_rx = d;
        check_eq("rx_valid", RX_VALID, 1);
        check_eq("rx_data", RX_DATA, model_rx);
        check_eq("rx_done_busy", BUSY, 0);
        check_eq("rx_done_ready", TX_READY, 1);
        check_eq("rx_done_pad_t", PAD_T, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        R        = 1'b1;
        TX_VALID = 1'b0;
        RX_REQ   = 1'b0;
        TX_DATA  = '0;
        PAD_O    = 1'b0;
        tick();
        tick();
        check_eq("rst_tx_ready", TX_READY, 0);
        check_eq("rst_pad_t", PAD_T, 1);
        check_eq("rst_pad_i", PAD_I, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_rx_valid", RX_VALID, 0);
        check_eq("rst_rx_data", RX_DATA, 0);
        R = 1'b0;
        #1;
        check_eq("post_rst_ready", TX_READY, 1);

        do_tx(8'hA5, 1'b0, 1'b0);
        idle_cycles(2);
        do_rx(8'h3C, 1'b0);
        idle_cycles(1);
        do_tx(8'hFF, 1'b1, 1'b1);
        idle_cycles(1);

        // Reset ten cycles into a transmit.
        TX_VALID = 1'b1;
        TX_DATA  = 8'hC3;
        tick();
        TX_VALID = 1'b0;
        repeat (10) tick();
        check_eq("abort_pre_pad_t", PAD_T, 0);
        R = 1'b1;
        tick();
        model_rx = '0;
        check_eq("abort_pad_t", PAD_T, 1);
        check_eq("abort_pad_i", PAD_I, 0);
        check_eq("abort_busy", BUSY, 0);
        check_eq("abort_ready_in_rst", TX_READY, 0);
        check_eq("abort_rx_data", RX_DATA, 0);
        R = 1'b0;
        #1;
        do_rx(8'h5A, 1'b0);
        idle_cycles(1);

        // Reset partway through a receive: no RX_VALID, RX_DATA cleared.
        RX_REQ = 1'b1;
        tick();
        RX_REQ = 1'b0;
        repeat (7) tick();
        R = 1'b1;
        tick();
        R = 1'b0;
        model_rx = '0;
        check_eq("rx_abort_busy", BUSY, 0);
        idle_cycles(3);

        // Back-to-back: TX accepted in the RX_VALID cycle.
        do_rx(8'h01, 1'b0);
        do_tx(8'h80, 1'b0, 1'b0);
        idle_cycles(1);

        for (int t = 0; t < 40; t++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_tx(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                do_rx(d, 1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
